mem_ctrl: RTL and testbench

- Bus master that drives the byte-wide synchronous RAM port from the CPU side.
- Converts word-level instruction-fetch requests and byte/half/word load/store requests into sequences of single-byte RAM accesses.
- Sits inside the core between the IF/MEM stages and the byte RAM. Arbitrates the two requesters and returns assembled, little-endian, optionally sign-extended data with a one-cycle done pulse.

---
 rtl/mem_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM master: word fetches and byte/half/word loads/stores become single-byte RAM cycles.
// Latency: read N+2 cycles, write N+1 cycles from the accept edge; data port wins arbitration.
// Requesters hold req until done; optional fetch buffer under MEM_CTRL_IBUF_EN.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              ram_ce,
  output logic              ram_r_nw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
  logic [2:0]        nb_q, nb_d, iss_q, iss_d;
  logic [1:0]        cap_q, cap_d;
  logic              pend_q, pend_d, is_mem_q, is_mem_d, sgn_q, sgn_d;
  logic [31:0]       wdat_q, wdat_d, dat_q, dat_d;
  logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic              ram_ce_q, ram_ce_d, ram_r_nw_q, ram_r_nw_d, busy_q, busy_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
`ifdef MEM_CTRL_IBUF_EN
  logic              hit_q, hit_d, vld_q, vld_d;
  logic [ADDR_W-1:0] ibuf_addr_q, ibuf_addr_d;
  logic [31:0]       ibuf_dat_q, ibuf_dat_d;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  function automatic logic [2:0] nbytes(input logic [1:0] s);
    case (s)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] n, input logic s);
    case (n)
      3'd1:    extend = {{24{s & d[7]}}, d[7:0]};
      3'd2:    extend = {{16{s & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nb_d        = nb_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    is_mem_d    = is_mem_q;
    sgn_d       = sgn_q;
    wdat_d      = wdat_q;
    dat_d       = dat_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_ce_d    = 1'b0;
    ram_r_nw_d  = 1'b1;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    // RAM returns data one cycle after a read is presented
    pend_d      = ram_ce_q & ram_r_nw_q;
`ifdef MEM_CTRL_IBUF_EN
    hit_d       = hit_q;
    vld_d       = vld_q;
    ibuf_addr_d = ibuf_addr_q;
    ibuf_dat_d  = ibuf_dat_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          base_d      = mem_addr[ADDR_W-1:0];
          nb_d        = nbytes(mem_size);
          is_mem_d    = 1'b1;
          sgn_d       = mem_signed;
          wdat_d      = mem_wdata;
          dat_d       = '0;
          iss_d       = 3'd1;
          cap_d       = '0;
          ram_ce_d    = 1'b1;
          ram_r_nw_d  = ~mem_we;
          ram_addr_d  = mem_addr[ADDR_W-1:0];
          ram_wdata_d = mem_wdata[7:0];
          state_d     = mem_we ? WRITE : READ;
`ifdef MEM_CTRL_IBUF_EN
          hit_d = 1'b0;
          if (mem_we) vld_d = 1'b0;
`endif
        end else if (if_req) begin
`ifdef MEM_CTRL_IBUF_EN
          if (vld_q && (if_addr[ADDR_W-1:0] == ibuf_addr_q)) begin
            state_d  = READ;
            hit_d    = 1'b1;
            is_mem_d = 1'b0;
          end else begin
            hit_d = 1'b0;
`else
          begin
`endif
            base_d     = if_addr[ADDR_W-1:0];
            nb_d       = 3'd4;
            is_mem_d   = 1'b0;
            sgn_d      = 1'b0;
            dat_d      = '0;
            iss_d      = 3'd1;
            cap_d      = '0;
            ram_ce_d   = 1'b1;
            ram_addr_d = if_addr[ADDR_W-1:0];
            state_d    = READ;
          end
        end
      end
      READ: begin
`ifdef MEM_CTRL_IBUF_EN
        if (hit_q) begin
          hit_d     = 1'b0;
          if_done_d = 1'b1;
          if_data_d = ibuf_dat_q;
          state_d   = DONE;
        end else
`endif
        begin
          if (iss_q < nb_q) begin
            ram_ce_d   = 1'b1;
            ram_addr_d = base_q + ADDR_W'(iss_q);
            iss_d      = iss_q + 3'd1;
          end
          if (pend_q) begin
            dat_d[8*cap_q +: 8] = ram_rdata;
            cap_d = cap_q + 2'd1;
            if ({1'b0, cap_q} == nb_q - 3'd1) begin
              state_d = DONE;
              if (is_mem_q) begin
                mem_done_d  = 1'b1;
                mem_rdata_d = extend(dat_d, nb_q, sgn_q);
              end else begin
                if_done_d = 1'b1;
                if_data_d = dat_d;
`ifdef MEM_CTRL_IBUF_EN
                vld_d       = 1'b1;
                ibuf_addr_d = base_q;
                ibuf_dat_d  = dat_d;
`endif
              end
            end
          end
        end
      end
      WRITE: begin
        if (iss_q < nb_q) begin
          ram_ce_d    = 1'b1;
          ram_r_nw_d  = 1'b0;
          ram_addr_d  = base_q + ADDR_W'(iss_q);
          ram_wdata_d = wdat_q[8*iss_q[1:0] +: 8];
          iss_d       = iss_q + 3'd1;
        end else begin
          mem_done_d = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      nb_q        <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      pend_q      <= 1'b0;
      is_mem_q    <= 1'b0;
      sgn_q       <= 1'b0;
      wdat_q      <= '0;
      dat_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_r_nw_q  <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_CTRL_IBUF_EN
      hit_q       <= 1'b0;
      vld_q       <= 1'b0;
      ibuf_addr_q <= '0;
      ibuf_dat_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nb_q        <= nb_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      pend_q      <= pend_d;
      is_mem_q    <= is_mem_d;
      sgn_q       <= sgn_d;
      wdat_q      <= wdat_d;
      dat_q       <= dat_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_ce_q    <= ram_ce_d;
      ram_r_nw_q  <= ram_r_nw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
`ifdef MEM_CTRL_IBUF_EN
      hit_q       <= hit_d;
      vld_q       <= vld_d;
      ibuf_addr_q <= ibuf_addr_d;
      ibuf_dat_q  <= ibuf_dat_d;
`endif
    end
  end

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_ce    = ram_ce_q;
  assign ram_r_nw  = ram_r_nw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte-RAM model and access log.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, mem_signed = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [1:0]  mem_size = '0;
  logic [31:0] if_data, mem_rdata;
  logic        if_done, mem_done, ram_ce, ram_r_nw, busy;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  mem_ctrl #(.ADDR_W(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_ce(ram_ce), .ram_r_nw(ram_r_nw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:131071];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_r_nw) ram_rdata <= ram[ram_addr];
      else          ram[ram_addr] <= ram_wdata;
    end
  end

  typedef struct {
    logic [16:0] a;
    logic        rnw;
    logic [7:0]  wd;
    int          cyc;
  } acc_t;
  acc_t log_q[$];
  int   cyc = 0;
  bit   both_seen = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (ram_ce) log_q.push_back('{a: ram_addr, rnw: ram_r_nw, wd: ram_wdata, cyc: cyc});
    if (if_done && mem_done) both_seen = 1'b1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access log must be n back-to-back cycles at base, base+1, ... (17-bit wrap)
  function automatic logic seq_ok(input logic [16:0] base, input int n, input logic rnw);
    logic [16:0] a;
    logic ok;
    ok = (log_q.size() == n);
    for (int i = 0; i < log_q.size() && i < n; i++) begin
      a  = base + 17'(i);
      ok = ok && (log_q[i].a == a) && (log_q[i].rnw == rnw) && (log_q[i].cyc == log_q[0].cyc + i);
    end
    return ok;
  endfunction

  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] d);
    log_q.delete();
    if_req  = 1'b1;
    if_addr = a;
    lat = 0;
    d   = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if_done) begin lat = k; d = if_data; break; end
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic mem_op(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    log_q.delete();
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_signed = sg;
    mem_addr = a; mem_wdata = wd;
    lat = 0;
    rd  = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_done) begin lat = k; rd = mem_rdata; break; end
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, lat2;
    logic [31:0] d, d2;
    int          mem_k, if_k;
    logic        wr_ok;

    ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h00; ram[17'h103] = 8'h00;
    ram[17'h1FFFF] = 8'h34; ram[17'h00000] = 8'h12;
    for (int i = 0; i < 4; i++) ram[17'h40 + 17'(i)] = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ce", {31'b0, ram_ce}, 32'd0);
    check("rst_rnw", {31'b0, ram_r_nw}, 32'd1);
    check("rst_dones", {30'b0, if_done, mem_done}, 32'd0);
    check("rst_data", if_data | mem_rdata, 32'd0);
    check("rst_addr", {15'b0, ram_addr}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    fetch(32'h100, lat, d);
    check("fetch_lat", lat, 32'd6);
    check("fetch_data", d, 32'h00000513);
    check("fetch_seq", {31'b0, seq_ok(17'h100, 4, 1'b1)}, 32'd1);

    mem_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, lat, d);
    wr_ok = seq_ok(17'h20, 4, 1'b0) && log_q[0].wd == 8'hEF && log_q[1].wd == 8'hBE
            && log_q[2].wd == 8'hAD && log_q[3].wd == 8'hDE;
    check("store_lat", lat, 32'd5);
    check("store_seq", {31'b0, wr_ok}, 32'd1);
    check("store_ram", {ram[17'h23], ram[17'h22], ram[17'h21], ram[17'h20]}, 32'hDEADBEEF);
    check("if_data_hold", if_data, 32'h00000513);

    mem_op(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, lat, d);
    check("lb_signed", d, 32'hFFFFFFAD);
    check("lb_lat", lat, 32'd3);
    mem_op(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, lat, d);
    check("lb_unsigned", d, 32'h000000AD);
    mem_op(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, d);
    check("lh_signed", d, 32'hFFFFBEEF);
    mem_op(1'b0, 2'b01, 1'b0, 32'h1FFFF, 32'h0, lat, d);
    check("lh_wrap_data", d, 32'h00001234);
    check("lh_wrap_lat", lat, 32'd4);
    check("lh_wrap_seq", {31'b0, seq_ok(17'h1FFFF, 2, 1'b1)}, 32'd1);

    // Simultaneous requests: data side first, fetch after the DONE/IDLE cycles
    log_q.delete();
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h100;
    mem_k = 0; if_k = 0; d = 'x; d2 = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_done) begin mem_k = k; d = mem_rdata; mem_req = 1'b0; end
      if (if_done) begin if_k = k; d2 = if_data; if_req = 1'b0; break; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("arb_mem_cycle", mem_k, 32'd6);
    check("arb_if_cycle", if_k, 32'd13);
    check("arb_mem_data", d, 32'hDEADBEEF);
    check("arb_if_data", d2, 32'h00000513);
    check("arb_rdata_hold", mem_rdata, 32'hDEADBEEF);
    check("never_both_done", {31'b0, both_seen}, 32'd0);

    // Reset while the third byte of a store is on the bus
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = 32'hA1B2C3D4;
    lat = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (mem_done) lat = k;
    end
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    check("rst_mid_ce", {31'b0, ram_ce}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    if (mem_done) lat = 99;
    check("rst_mid_nodone", lat, 32'd0);
    check("rst_mid_ram", {ram[17'h43], ram[17'h42], ram[17'h41], ram[17'h40]}, 32'h0000C3D4);
    check("rst_mid_if_data", if_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    fetch(32'h100, lat, d);
    check("fetch1_lat", lat, 32'd6);
    fetch(32'h100, lat2, d2);
    check("fetch2_data", d2, 32'h00000513);
`ifdef MEM_CTRL_IBUF_EN
    check("fetch2_lat", lat2, 32'd2);
    check("fetch2_reads", log_q.size(), 32'd0);
`else
    check("fetch2_lat", lat2, 32'd6);
    check("fetch2_reads", log_q.size(), 32'd4);
`endif
    mem_op(1'b1, 2'b00, 1'b0, 32'h300, 32'h5A, lat, d);
    check("sb_ram", {24'b0, ram[17'h300]}, 32'h5A);
    fetch(32'h100, lat, d);
    check("fetch3_lat", lat, 32'd6);
    check("fetch3_reads", {31'b0, seq_ok(17'h100, 4, 1'b1)}, 32'd1);
    check("fetch3_data", d, 32'h00000513);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
